// File: rtl/led_pattern_driver.sv
// led_pattern_driver: registered, parametrised LED pattern generator.
// Renders a captured value as one-hot, thermometer bar, chase animation
// or blink on N_LEDS outputs. Animation and blink advance on tick_en.
// Compile-time option: define LED_BLINK_EN to enable the blink mode (3).
// Without it, mode 3 renders exactly like mode 0 and BLINK_TICKS is unused.

module led_pattern_driver #(
  parameter int N_LEDS      = 15,
  parameter int VAL_W       = 4,
  parameter int BLINK_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_en,
  input  logic              load,
  input  logic [VAL_W-1:0]  val_in,
  input  logic [1:0]        mode_in,
  output logic [N_LEDS-1:0] led,
  output logic              oor
);

  // Comparison width: wide enough for both the value and N_LEDS (up to 64).
  localparam int CMP_W = (VAL_W > 7) ? VAL_W : 7;
  // Chase position width; at least one bit so N_LEDS=1 still elaborates.
  localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  localparam logic [CMP_W-1:0] N_LEDS_C = CMP_W'(N_LEDS);

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'd0,
    MODE_THERM  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  // Reject illegal parameter combinations at elaboration.
  if (N_LEDS < 1 || N_LEDS > 64 || (1 << VAL_W) <= N_LEDS || BLINK_TICKS < 1) begin : g_bad_params
    $error("led_pattern_driver: illegal parameter combination");
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [VAL_W-1:0]  val_q, val_d;
  mode_e             mode_q, mode_d;
  logic [POS_W-1:0]  chase_pos_q, chase_pos_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              oor_q, oor_d;

  // Value and chase position extended to the common comparison width.
  logic [CMP_W-1:0]  v_cur;
  logic [CMP_W-1:0]  v_nxt;
  logic [CMP_W-1:0]  pos_cur;
  logic [CMP_W-1:0]  pos_nxt;
  logic [CMP_W-1:0]  span;
  logic              phase_on;

  assign v_cur   = CMP_W'(val_q);
  assign v_nxt   = CMP_W'(val_d);
  assign pos_cur = CMP_W'(chase_pos_q);
  assign pos_nxt = CMP_W'(chase_pos_d);

  // Chase span: the value itself when it is in range, otherwise all LEDs.
  assign span = (v_cur >= CMP_W'(1) && v_cur <= N_LEDS_C) ? v_cur : N_LEDS_C;

`ifdef LED_BLINK_EN
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  // Blink counter/phase next state: load restarts the "on" half-period,
  // each tick in blink mode counts toward the next phase toggle.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (load) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (tick_en && mode_q == MODE_BLINK) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Blink state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign phase_on = blink_phase_d;
`else
  // Without blink support mode 3 is a plain one-hot display.
  assign phase_on = 1'b1;
`endif

  // Value/mode capture and chase position next state; load beats tick.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (which would infer a latch).
    val_d       = val_q;
    mode_d      = mode_q;
    chase_pos_d = chase_pos_q;
    if (load) begin
      val_d       = val_in;
      mode_d      = mode_e'(mode_in);
      chase_pos_d = '0;
    end else if (tick_en && mode_q == MODE_CHASE && v_cur != '0) begin
      if (pos_cur == span - CMP_W'(1)) begin
        chase_pos_d = '0;
      end else begin
        chase_pos_d = chase_pos_q + POS_W'(1);
      end
    end
  end

  // LED pattern and range flag, computed from the next-state values so
  // load and animation steps appear on the same edge.
  always_comb begin
    led_d = '0;
    oor_d = (v_nxt > N_LEDS_C);
    for (int i = 0; i < N_LEDS; i++) begin
      unique case (mode_d)
        MODE_ONEHOT: led_d[i] = (v_nxt == CMP_W'(i + 1));
        MODE_THERM:  led_d[i] = (v_nxt > CMP_W'(i));
        MODE_CHASE:  led_d[i] = (v_nxt != '0) && (pos_nxt == CMP_W'(i));
        MODE_BLINK:  led_d[i] = phase_on && (v_nxt == CMP_W'(i + 1));
        default:     led_d[i] = 1'b0;
      endcase
    end
  end

  // Main state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      val_q       <= '0;
      mode_q      <= MODE_ONEHOT;
      chase_pos_q <= '0;
      led_q       <= '0;
      oor_q       <= 1'b0;
    end else begin
      val_q       <= val_d;
      mode_q      <= mode_d;
      chase_pos_q <= chase_pos_d;
      led_q       <= led_d;
      oor_q       <= oor_d;
    end
  end

  assign led = led_q;
  assign oor = oor_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed testbench for led_pattern_driver. A 15-LED and a 10-LED instance
// share stimulus; each check targets the instance relevant to the vector.
// Blink expectations follow whether LED_BLINK_EN is defined for the build.

module tb_led_pattern_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_en;
  logic        load;
  logic [3:0]  val_in;
  logic [1:0]  mode_in;
  logic [14:0] led15;
  logic        oor15;
  logic [9:0]  led10;
  logic        oor10;

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_driver #(.N_LEDS(15), .VAL_W(4), .BLINK_TICKS(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_en (tick_en),
    .load    (load),
    .val_in  (val_in),
    .mode_in (mode_in),
    .led     (led15),
    .oor     (oor15)
  );

  led_pattern_driver #(.N_LEDS(10), .VAL_W(4), .BLINK_TICKS(2)) dut10 (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_en (tick_en),
    .load    (load),
    .val_in  (val_in),
    .mode_in (mode_in),
    .led     (led10),
    .oor     (oor10)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the edge, strobes drop.
  task automatic cycle();
    @(posedge clk);
    #1;
    load    = 1'b0;
    tick_en = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v, input logic [1:0] m);
    val_in  = v;
    mode_in = m;
    load    = 1'b1;
    cycle();
  endtask

  task automatic do_tick();
    tick_en = 1'b1;
    cycle();
  endtask

  initial begin
    logic [14:0] blink_exp [5];
    logic [14:0] chase_exp [5];
    chase_exp = '{15'h2, 15'h4, 15'h8, 15'h1, 15'h2};
`ifdef LED_BLINK_EN
    blink_exp = '{15'h2, 15'h2, 15'h0, 15'h0, 15'h2};
`else
    blink_exp = '{15'h2, 15'h2, 15'h2, 15'h2, 15'h2};
`endif

    rst_n   = 1'b0;
    tick_en = 1'b0;
    load    = 1'b0;
    val_in  = '0;
    mode_in = '0;
    cycle();
    cycle();
    check("reset_led", 64'(led15), 64'h0);
    check("reset_oor", 64'(oor15), 64'h0);
    rst_n = 1'b1;

    // One-hot
    do_load(4'd5, 2'd0);
    check("onehot_5", 64'(led15), 64'h0010);
    check("onehot_5_oor", 64'(oor15), 64'h0);
    do_load(4'd0, 2'd0);
    check("onehot_0", 64'(led15), 64'h0);
    do_load(4'd15, 2'd0);
    check("onehot_15", 64'(led15), 64'h4000);
    check("onehot_15_oor", 64'(oor15), 64'h0);
    check("onehot_15_n10", 64'(led10), 64'h0);
    check("onehot_15_n10_oor", 64'(oor10), 64'h1);

    // Thermometer
    do_load(4'd3, 2'd1);
    check("therm_3", 64'(led15), 64'h0007);
    do_load(4'd12, 2'd1);
    check("therm_12_n10", 64'(led10), 64'h3FF);
    check("therm_12_n10_oor", 64'(oor10), 64'h1);
    check("therm_12_n15", 64'(led15), 64'h0FFF);
    do_load(4'd0, 2'd1);
    check("therm_0", 64'(led15), 64'h0);

    // Chase, span 4
    do_load(4'd4, 2'd2);
    check("chase_start", 64'(led15), 64'h1);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      check($sformatf("chase_tick%0d", i + 1), 64'(led15), 64'(chase_exp[i]));
    end
    cycle();
    cycle();
    check("chase_hold", 64'(led15), 64'h2);

    // Load and tick together at chase_pos=2: load wins
    do_tick();
    check("chase_pos2", 64'(led15), 64'h4);
    val_in  = 4'd4;
    mode_in = 2'd2;
    load    = 1'b1;
    tick_en = 1'b1;
    cycle();
    check("load_beats_tick", 64'(led15), 64'h1);
    do_tick();
    check("after_load_tick", 64'(led15), 64'h2);

    // Chase span 1 stays on led[0]
    do_load(4'd1, 2'd2);
    do_tick();
    do_tick();
    check("chase_span1", 64'(led15), 64'h1);

    // Chase with value 0 stays dark
    do_load(4'd0, 2'd2);
    do_tick();
    check("chase_v0", 64'(led15), 64'h0);

    // Out-of-range chase wraps at N_LEDS on the 10-LED instance
    do_load(4'd12, 2'd2);
    for (int i = 0; i < 9; i++) do_tick();
    check("chase_oor_last", 64'(led10), 64'h200);
    do_tick();
    check("chase_oor_wrap", 64'(led10), 64'h001);

    // Blink
    do_load(4'd2, 2'd3);
    check("blink_t0", 64'(led15), 64'(blink_exp[0]));
    for (int i = 1; i < 5; i++) begin
      do_tick();
      check($sformatf("blink_t%0d", i), 64'(led15), 64'(blink_exp[i]));
    end

    // Reset mid-chase, overriding a simultaneous load and tick
    do_load(4'd4, 2'd2);
    do_tick();
    do_tick();
    do_tick();
    check("chase_pos3", 64'(led15), 64'h8);
    rst_n   = 1'b0;
    val_in  = 4'd7;
    mode_in = 2'd1;
    load    = 1'b1;
    tick_en = 1'b1;
    cycle();
    check("midreset_led", 64'(led15), 64'h0);
    check("midreset_oor", 64'(oor10), 64'h0);
    rst_n = 1'b1;
    do_tick();
    cycle();
    check("post_reset_idle", 64'(led15), 64'h0);
    check("post_reset_idle_n10", 64'(led10), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
